// File: rtl/inv_reg_chain_pkg.sv
// Shared encodings for the inverter register chain: shift-mode codes and
// step-counter FSM states.
package inv_reg_chain_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_WRITE  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Only SHIFT and ROTATE move data, so only they consume a counted step.
    function automatic logic is_move(input mode_e mode);
        return (mode == MODE_SHIFT) || (mode == MODE_ROTATE);
    endfunction

endpackage

// File: rtl/inv_step_counter.sv
// Counted-run controller: loads a step budget on start, decrements on each
// enabled SHIFT/ROTATE, and raises a one-cycle done when the budget is spent.
module inv_step_counter
    import inv_reg_chain_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             init,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] num_steps,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             step_move;

    assign step_move = en && is_move(mode_e'(mode));

    // NOTE: state and outputs share one clocked block with non-blocking
    // assignments only; busy/done are registered so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (en && init) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else if (start) begin
                if (num_steps == '0) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= ST_RUN;
                    cnt_q   <= num_steps;
                    busy_q  <= 1'b1;
                end
            end else if (state_q == ST_RUN && step_move) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/inv_reg_chain.sv
// Chain of DEPTH M-bit stages with hold/shift/rotate/write modes, a tap mux
// and a counted-run controller that tracks how many moves have been made.
module inv_reg_chain
    import inv_reg_chain_pkg::*;
#(
    parameter int M     = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     init,
    input  logic [M-1:0]             reg_init,
    input  logic [M-1:0]             reg_in,
    input  logic [1:0]               mode,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [$clog2(DEPTH)-1:0] tap_sel,
    input  logic                     start,
    input  logic [CNT_W-1:0]         num_steps,
    output logic [M-1:0]             reg_out,
    output logic [M-1:0]             tap_out,
    output logic                     busy,
    output logic                     done
);

    logic [M-1:0] stage_q [DEPTH];
    logic [M-1:0] stage_d [DEPTH];
    mode_e        mode_v;

    assign mode_v = mode_e'(mode);

    // NOTE: combinational next-state uses blocking assignments and starts
    // from a full default copy, so no path can infer a latch.
    always_comb begin
        stage_d = stage_q;
        if (en && init) begin
            for (int i = 0; i < DEPTH; i++) stage_d[i] = reg_init;
        end else if (en) begin
            case (mode_v)
                MODE_SHIFT: begin
                    stage_d[0] = reg_in;
                    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
                end
                MODE_ROTATE: begin
                    stage_d[0] = stage_q[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
                end
                MODE_WRITE: begin
                    // An index past the last stage matches nothing and writes nothing.
                    for (int i = 0; i < DEPTH; i++)
                        if (int'(wr_idx) == i) stage_d[i] = reg_in;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the stage array is plain flops, not RAM, so it takes the reset
    // like any other register and reads back zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    always_comb begin
        tap_out = '0;
        for (int i = 0; i < DEPTH; i++)
            if (int'(tap_sel) == i) tap_out = stage_q[i];
    end

    assign reg_out = stage_q[DEPTH-1];

    inv_step_counter #(
        .CNT_W(CNT_W)
    ) u_step_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .init     (init),
        .mode     (mode),
        .start    (start),
        .num_steps(num_steps),
        .busy     (busy),
        .done     (done)
    );

endmodule

// File: tb/tb_inv_reg_chain.sv
// Scoreboard bench: stimulus pushes the model's expected outputs per edge,
// a monitor pops and compares them just after each rising edge.
module tb_inv_reg_chain;

    localparam int M     = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] SHIFT  = 2'b01;
    localparam logic [1:0] ROTATE = 2'b10;
    localparam logic [1:0] WRITE  = 2'b11;

    logic             clk = 1'b0;
    logic             rst, en, init, start;
    logic [M-1:0]     reg_init, reg_in;
    logic [1:0]       mode;
    logic [IDX_W-1:0] wr_idx, tap_sel;
    logic [CNT_W-1:0] num_steps;
    logic [M-1:0]     reg_out, tap_out;
    logic             busy, done;

    typedef struct packed {
        logic [M-1:0] reg_out;
        logic [M-1:0] tap_out;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: chain as a queue (index 0 = first stage) plus a run budget.
    logic [M-1:0] mstage[$];
    bit           running = 0;
    int           remaining = 0;
    bit           mdone = 0;

    inv_reg_chain #(.M(M), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .init     (init),
        .reg_init (reg_init),
        .reg_in   (reg_in),
        .mode     (mode),
        .wr_idx   (wr_idx),
        .tap_sel  (tap_sel),
        .start    (start),
        .num_steps(num_steps),
        .reg_out  (reg_out),
        .tap_out  (tap_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Apply the spec's rules to the model for the inputs now driven, push the
    // expected post-edge outputs, then wait for the following falling edge.
    task automatic tick();
        exp_t         e;
        logic [M-1:0] tmp;
        bit           moved;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mstage[i] = '0;
            running = 0; remaining = 0; mdone = 0;
        end else begin
            moved = en && !init && (mode == SHIFT || mode == ROTATE);
            if (en && init) begin
                for (int i = 0; i < DEPTH; i++) mstage[i] = reg_init;
            end else if (en && mode == SHIFT) begin
                mstage.push_front(reg_in);
                tmp = mstage.pop_back();
            end else if (en && mode == ROTATE) begin
                tmp = mstage.pop_back();
                mstage.push_front(tmp);
            end else if (en && mode == WRITE && int'(wr_idx) < DEPTH) begin
                mstage[wr_idx] = reg_in;
            end
            mdone = 0;
            if (en && init) begin
                running = 0;
            end else if (start) begin
                if (num_steps == 0) begin
                    running = 0; mdone = 1;
                end else begin
                    running = 1; remaining = int'(num_steps);
                end
            end else if (running && moved) begin
                remaining--;
                if (remaining == 0) begin
                    running = 0; mdone = 1;
                end
            end
        end
        e.reg_out = mstage[DEPTH-1];
        e.tap_out = (int'(tap_sel) < DEPTH) ? mstage[tap_sel] : '0;
        e.busy    = running;
        e.done    = mdone;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_reg_out", 32'(reg_out), 32'(e.reg_out));
            check("sb_tap_out", 32'(tap_out), 32'(e.tap_out));
            check("sb_busy",    32'(busy),    32'(e.busy));
            check("sb_done",    32'(done),    32'(e.done));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [M-1:0] shift_exp [4];
        shift_exp[0] = 16'h00A5; shift_exp[1] = 16'h00A5;
        shift_exp[2] = 16'h00A5; shift_exp[3] = 16'h0001;
        for (int i = 0; i < DEPTH; i++) mstage.push_back(16'hDEAD);

        rst = 1; en = 0; init = 0; start = 0; reg_init = '0; reg_in = '0;
        mode = HOLD; wr_idx = '0; tap_sel = '0; num_steps = '0;
        tick(); tick();
        rst = 0;
        tick();
        check("rst_reg_out", 32'(reg_out), 0);
        check("rst_tap_out", 32'(tap_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);

        // Init then shift 1..4: last stage shows the init value three times.
        en = 1; init = 1; reg_init = 16'h00A5;
        tick();
        init = 0; mode = SHIFT;
        for (int v = 1; v <= 4; v++) begin
            reg_in = M'(v);
            tick();
            check("shift_reg_out", 32'(reg_out), 32'(shift_exp[v-1]));
        end
        mode = HOLD; tap_sel = 0;
        #1 check("shift_tap0", 32'(tap_out), 4);
        tick();

        // Counted rotate of 4 steps returns the chain to where it started.
        start = 1; num_steps = 4;
        tick();
        start = 0; mode = ROTATE;
        for (int i = 0; i < 4; i++) begin
            check("rot_busy", 32'(busy), 1);
            check("rot_done_low", 32'(done), 0);
            tick();
        end
        mode = HOLD;
        check("rot_busy_end", 32'(busy), 0);
        check("rot_done_pulse", 32'(done), 1);
        tick();
        check("rot_done_once", 32'(done), 0);
        for (int i = 0; i < DEPTH; i++) begin
            tap_sel = IDX_W'(i);
            #1 check("rot_restore", 32'(tap_out), 32'(4 - i));
        end

        // Three steps with two frozen cycles: done lands 5 edges after busy rises.
        start = 1; num_steps = 3;
        tick();
        start = 0; mode = SHIFT; reg_in = 16'h0011;
        tick();
        en = 0; tick(); tick();
        en = 1; tick();
        check("frz_busy_4", 32'(busy), 1);
        check("frz_done_4", 32'(done), 0);
        tick();
        check("frz_busy_5", 32'(busy), 0);
        check("frz_done_5", 32'(done), 1);

        // Init mid-run aborts with no done and loads every stage.
        mode = HOLD; start = 1; num_steps = 5;
        tick();
        start = 0; mode = ROTATE;
        tick();
        init = 1; reg_init = 16'h1234;
        tick();
        init = 0; mode = HOLD;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        for (int i = 0; i < DEPTH; i++) begin
            tap_sel = IDX_W'(i);
            #1 check("abort_stage", 32'(tap_out), 32'h1234);
        end
        tick();
        check("abort_no_done", 32'(done), 0);

        // Zero-length run and a targeted write.
        start = 1; num_steps = 0;
        tick();
        start = 0;
        check("zero_busy", 32'(busy), 0);
        check("zero_done", 32'(done), 1);
        mode = WRITE; wr_idx = 2; reg_in = 16'hBEEF;
        tick();
        check("zero_done_once", 32'(done), 0);
        mode = HOLD; tap_sel = 2;
        #1 check("write_tap2", 32'(tap_out), 32'hBEEF);
        tick();

        // Randomised traffic, including occasional mid-run reset and init.
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            en        = ($urandom_range(0, 3) != 0);
            init      = ($urandom_range(0, 19) == 0);
            start     = ($urandom_range(0, 9) == 0);
            num_steps = CNT_W'($urandom_range(0, 6));
            mode      = 2'($urandom_range(0, 3));
            reg_in    = M'($urandom);
            reg_init  = M'($urandom);
            wr_idx    = IDX_W'($urandom_range(0, DEPTH - 1));
            tap_sel   = IDX_W'($urandom_range(0, DEPTH - 1));
            tick();
        end

        rst = 0; en = 0; init = 0; start = 0; mode = HOLD;
        @(posedge clk); #2;
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/inv_reg_chain.md
INV_REG_CHAIN -- requirements
Module: inv_reg_chain

Interface
REQ-001 Parameter M, default 16, data width of each stage (GF(2^m) element).
REQ-002 Parameter DEPTH, default 4, number of chained stages (2..16).
REQ-003 Parameter CNT_W, default 8, width of the step counter.
REQ-004 clk  input  1  sole clock; every register updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  global update enable; en=0 freezes stages and counter.
REQ-007 init  input  1  load every stage with reg_init (when en=1).
REQ-008 reg_init  input  M  initialisation value.
REQ-009 reg_in  input  M  data for shift or write modes.
REQ-010 mode  input  2  00 HOLD, 01 SHIFT, 10 ROTATE, 11 WRITE.
REQ-011 wr_idx  input  clog2(DEPTH)  target stage in WRITE mode.
REQ-012 tap_sel  input  clog2(DEPTH)  stage routed to tap_out.
REQ-013 start  input  1  one-cycle pulse; begins a counted run.
REQ-014 num_steps  input  CNT_W  number of SHIFT/ROTATE steps in the run.
REQ-015 reg_out  output  M  stage[DEPTH-1].
REQ-016 tap_out  output  M  stage[tap_sel], combinational mux of registered stages.
REQ-017 busy  output  1  counted run in progress.
REQ-018 done  output  1  one-cycle pulse at end of a counted run.

Function
REQ-019 Update priority per edge: rst > (en & init) > (en & mode action) > hold.
REQ-020 en=1, init=1: all stages <= reg_init; busy <= 0; done <= 0; mode ignored.
REQ-021 SHIFT: stage[0] <= reg_in; stage[i] <= stage[i-1] for i=1..DEPTH-1.
REQ-022 ROTATE: stage[0] <= stage[DEPTH-1]; stage[i] <= stage[i-1]; reg_in ignored.
REQ-023 WRITE: stage[wr_idx] <= reg_in; others unchanged; wr_idx >= DEPTH writes nothing.
REQ-024 HOLD, or en=0: all stages unchanged.
REQ-025 Stage movement is independent of busy; counter only counts moves.
REQ-026 Counter FSM states IDLE, RUN; reset state IDLE.
REQ-027 IDLE, start=1, num_steps>0: cnt <= num_steps, go RUN, busy=1 from next cycle.
REQ-028 IDLE, start=1, num_steps=0: stay IDLE, done=1 next cycle, no stage effect from the counter.
REQ-029 RUN, en=1, mode SHIFT or ROTATE, init=0: cnt decrements by 1.
REQ-030 RUN, decrement from 1 to 0: next cycle IDLE, busy=0, done=1 for exactly one cycle.
REQ-031 RUN, en=0 or mode HOLD/WRITE: cnt unchanged, stays RUN.
REQ-032 start during RUN: reloads cnt with num_steps (num_steps=0 ends run with done next cycle).
REQ-033 init during RUN: aborts to IDLE, busy=0, no done pulse.
REQ-034 start and init same cycle with en=1: init wins, start ignored.
REQ-035 start is honoured regardless of en.

Reset
REQ-036 On rst=1 at an edge: all stages 0, cnt 0, state IDLE, busy 0, done 0; reg_out and tap_out read 0 next cycle.
REQ-037 rst mid-run abandons the run without a done pulse.

Structure
REQ-038 Shared package holds mode encodings (MODE_HOLD/SHIFT/ROTATE/WRITE) and FSM state encodings.
REQ-039 One sub-module, inv_step_counter, implements the IDLE/RUN counter and busy/done; stages live in the top.

Verification
REQ-040 rst=1 then release -> reg_out=0, tap_out=0, busy=0, done=0.
REQ-041 M=16, DEPTH=4: init with 0x00A5, then SHIFT reg_in 1,2,3,4 -> reg_out sequence 0x00A5,0x00A5,0x00A5,1; tap_sel=0 reads 4 at end.
REQ-042 Stages {1,2,3,4}, start num_steps=4, mode ROTATE -> busy 4 cycles, done pulses once, stages return to {1,2,3,4}.
REQ-043 start num_steps=3 with en toggled low 2 cycles mid-run -> done exactly 5 cycles after busy rises.
REQ-044 init asserted during RUN -> busy drops next cycle, no done, all stages equal reg_init.
REQ-045 start num_steps=0 -> busy stays 0, done=1 for one cycle; WRITE wr_idx=2 value 0xBEEF -> tap_sel=2 reads 0xBEEF.
